// File: rtl/trans_pkg.sv
// ============================================================================
// Module : trans_pkg
// Brief  : Shared defaults, bank state encoding and index-width helper for the
//          column-write transpose buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package trans_pkg;

  localparam int c_WORD_WID  = 8;
  localparam int c_CH_X      = 32;
  localparam int c_NUM_WORDS = 16;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_t;

  // Counter width that stays legal for a degenerate single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trans_ybuf_bank.sv
// ============================================================================
// Module : trans_ybuf_bank
// Brief  : Tile storage, written one column per beat, read one row at a time.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module trans_ybuf_bank
  import trans_pkg::*;
#(
  parameter int WORD_WID  = c_WORD_WID,
  parameter int CH_X      = c_CH_X,
  parameter int NUM_WORDS = c_NUM_WORDS
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [idx_w(CH_X)-1:0]        i_col,
  input  logic [NUM_WORDS*WORD_WID-1:0] i_col_data,
  input  logic [idx_w(NUM_WORDS)-1:0]   i_row,
  output logic [CH_X*WORD_WID-1:0]      o_row_data
);

  logic [WORD_WID-1:0] r_mem [NUM_WORDS][CH_X];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int n = 0; n < NUM_WORDS; n++) begin
        r_mem[n][i_col] <= i_col_data[n*WORD_WID +: WORD_WID];
      end
    end
  end

  always_comb begin
    o_row_data = '0;
    for (int m = 0; m < CH_X; m++) begin
      o_row_data[m*WORD_WID +: WORD_WID] = r_mem[i_row][m];
    end
  end

endmodule

`default_nettype wire

// File: rtl/trans_ybuf_colwr.sv
// ============================================================================
// Module : trans_ybuf_colwr
// Brief  : Column-in / row-out transpose buffer. Define TRANS_YBUF_PINGPONG_EN
//          for two banks (fill one while draining the other); default is one.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module trans_ybuf_colwr
  import trans_pkg::*;
#(
  parameter int WORD_WID  = c_WORD_WID,
  parameter int CH_X      = c_CH_X,
  parameter int NUM_WORDS = c_NUM_WORDS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_WORDS*WORD_WID-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_X*WORD_WID-1:0]      out_data,
  output logic                          out_last,
  output logic                          busy
);

`ifdef TRANS_YBUF_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int CW = idx_w(CH_X);
  localparam int RW = idx_w(NUM_WORDS);

  bank_state_t             r_state [NB];
  logic [CW-1:0]           r_col_cnt;
  logic [RW-1:0]           r_row_cnt;
  logic                    r_fill_ptr;
  logic                    r_rd_ptr;
  logic [CH_X*WORD_WID-1:0] w_row [NB];

  logic w_in_fire, w_out_fire, w_col_last, w_row_last;

  assign in_ready   = (r_state[r_fill_ptr] == ST_EMPTY) ||
                      (r_state[r_fill_ptr] == ST_FILLING);
  // A FULL read bank is presented immediately; it becomes DRAINING next edge.
  assign out_valid  = (r_state[r_rd_ptr] == ST_FULL) ||
                      (r_state[r_rd_ptr] == ST_DRAINING);
  assign w_col_last = (r_col_cnt == CW'(CH_X - 1));
  assign w_row_last = (r_row_cnt == RW'(NUM_WORDS - 1));
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign out_last   = out_valid && w_row_last;
  assign out_data   = w_row[r_rd_ptr];

  always_comb begin
    busy = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (r_state[b] != ST_EMPTY) busy = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) r_state[b] <= ST_EMPTY;
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_fill_ptr <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_col_cnt <= w_col_last ? '0 : r_col_cnt + 1'b1;
`ifdef TRANS_YBUF_PINGPONG_EN
        if (w_col_last) r_fill_ptr <= ~r_fill_ptr;
`endif
      end
      if (w_out_fire) begin
        r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
`ifdef TRANS_YBUF_PINGPONG_EN
        if (w_row_last) r_rd_ptr <= ~r_rd_ptr;
`endif
      end
      // Fill and drain never target the same bank in one cycle: their
      // enabling states are disjoint.
      for (int b = 0; b < NB; b++) begin
        if (w_out_fire && w_row_last && (r_rd_ptr == 1'(b))) begin
          r_state[b] <= ST_EMPTY;
        end else if ((r_state[b] == ST_FULL) && (r_rd_ptr == 1'(b))) begin
          r_state[b] <= ST_DRAINING;
        end else if (w_in_fire && (r_fill_ptr == 1'(b))) begin
          r_state[b] <= w_col_last ? ST_FULL : ST_FILLING;
        end
      end
    end
  end

  for (genvar gb = 0; gb < NB; gb++) begin : g_bank
    trans_ybuf_bank #(
      .WORD_WID  (WORD_WID),
      .CH_X      (CH_X),
      .NUM_WORDS (NUM_WORDS)
    ) u_bank (
      .clk        (clk),
      .i_we       (w_in_fire && (r_fill_ptr == 1'(gb))),
      .i_col      (r_col_cnt),
      .i_col_data (in_data),
      .i_row      (r_row_cnt),
      .o_row_data (w_row[gb])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_trans_ybuf_colwr.sv
// ============================================================================
// Module : tb_trans_ybuf_colwr
// Brief  : Directed bench for trans_ybuf_colwr (default geometry 8/32/16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_trans_ybuf_colwr;

  localparam int W  = 8;
  localparam int CX = 32;
  localparam int NW = 16;
  localparam int TO = 3000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NW*W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CX*W-1:0] out_data;
  logic            out_last;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trans_ybuf_colwr #(.WORD_WID(W), .CH_X(CX), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Tile t tags every word by XOR so tiles are distinguishable; t=0 is the plain pattern.
  function automatic logic [NW*W-1:0] col_data(input int t, input int c);
    logic [7:0] tag;
    tag = 8'(t) * 8'h35;
    col_data = '0;
    for (int n = 0; n < NW; n++) col_data[n*W +: W] = {4'(c), 4'(n)} ^ tag;
  endfunction

  function automatic logic [CX*W-1:0] exp_row(input int t, input int r);
    logic [7:0] tag;
    tag = 8'(t) * 8'h35;
    exp_row = '0;
    for (int m = 0; m < CX; m++) exp_row[m*W +: W] = {4'(m), 4'(r)} ^ tag;
  endfunction

  // Entered and left at a negedge; each beat is taken at the following posedge.
  task automatic send_cols(input int t, input int c0, input int c1, output int waits);
    waits = 0;
    for (int c = c0; c <= c1; c++) begin
      int w;
      in_valid = 1'b1;
      in_data  = col_data(t, c);
      w = 0;
      while (!in_ready && w < TO) begin
        @(negedge clk);
        w++;
      end
      waits += w;
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL send_timeout tile=%0d col=%0d in_ready=%0b required=1", t, c, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_tile(input int t, output int first_wait, output int gaps);
    out_ready  = 1'b1;
    first_wait = 0;
    gaps       = 0;
    for (int r = 0; r < NW; r++) begin
      int w;
      w = 0;
      while (!out_valid && w < TO) begin
        @(negedge clk);
        w++;
      end
      if (r == 0) first_wait = w; else gaps += w;
      total++;
      if (!out_valid) begin
        bad++;
        $display("FAIL recv_timeout tile=%0d row=%0d out_valid=%0b required=1", t, r, out_valid);
      end
      total++;
      if (out_data !== exp_row(t, r)) begin
        bad++;
        $display("FAIL row_data tile=%0d row=%0d got=%h required=%h", t, r, out_data, exp_row(t, r));
      end
      total++;
      if (out_last !== (r == NW - 1)) begin
        bad++;
        $display("FAIL row_last tile=%0d row=%0d got=%0b required=%0b", t, r, out_last, (r == NW - 1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready  !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
    total++; if (out_last  !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b required=0", out_last); end
    total++; if (busy      !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b required=0", busy); end
  endtask

  task automatic test_single_tile;
    int w, fw, gp;
    out_ready = 1'b0;
    send_cols(0, 0, 30, w);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b required=0", out_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b required=1", busy); end
    send_cols(0, 31, 31, w);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency out_valid=%0b required=1", out_valid); end
    recv_tile(0, fw, gp);
    total++; if (gp !== 0) begin bad++; $display("FAIL single_gaps got=%0d required=0", gp); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%0b required=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%0b required=0", busy); end
  endtask

  task automatic test_stall;
    int w;
    out_ready = 1'b0;
    send_cols(1, 0, 31, w);
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      total++;
      if (out_data !== exp_row(1, r)) begin bad++; $display("FAIL stall_pre row=%0d got=%h required=%h", r, out_data, exp_row(1, r)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_last !== 1'b0 || out_data !== exp_row(1, 3)) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d valid=%0b last=%0b data=%h required=1/0/%h", k, out_valid, out_last, out_data, exp_row(1, 3));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int r = 4; r < NW; r++) begin
      total++;
      if (out_data !== exp_row(1, r) || out_last !== (r == NW - 1)) begin
        bad++;
        $display("FAIL stall_post row=%0d data=%h last=%0b required=%h/%0b", r, out_data, out_last, exp_row(1, r), (r == NW - 1));
      end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_done_busy got=%0b required=0", busy); end
  endtask

`ifdef TRANS_YBUF_PINGPONG_EN
  task automatic test_stream;
    int pw [4];
    int fw [4];
    int gp [4];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    fork
      begin
        for (int t = 0; t < 4; t++) send_cols(10 + t, 0, CX - 1, pw[t]);
      end
      begin
        for (int t = 0; t < 4; t++) recv_tile(10 + t, fw[t], gp[t]);
      end
    join
    for (int t = 0; t < 4; t++) begin
      total++; if (pw[t] !== 0) begin bad++; $display("FAIL stream_in_ready_drop tile=%0d stalls=%0d required=0", t, pw[t]); end
      total++; if (gp[t] !== 0) begin bad++; $display("FAIL stream_row_gaps tile=%0d got=%0d required=0", t, gp[t]); end
      total++;
      if (fw[t] !== ((t == 0) ? 32 : 16)) begin
        bad++;
        $display("FAIL stream_first_row tile=%0d wait=%0d required=%0d", t, fw[t], (t == 0) ? 32 : 16);
      end
    end
  endtask

  task automatic test_same_edge;
    int w;
    out_ready = 1'b0;
    send_cols(6, 0, 31, w);
    send_cols(7, 0, 30, w);
    out_ready = 1'b1;
    for (int r = 0; r < NW - 1; r++) @(negedge clk);
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL same_edge_setup last=%0b required=1", out_last); end
    in_valid = 1'b1;
    in_data  = col_data(7, 31);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== exp_row(7, 0) || out_last !== 1'b0) begin
      bad++;
      $display("FAIL same_edge_next valid=%0b last=%0b data=%h required=1/0/%h", out_valid, out_last, out_data, exp_row(7, 0));
    end
    begin
      int fw, gp;
      recv_tile(7, fw, gp);
      total++; if (fw !== 0 || gp !== 0) begin bad++; $display("FAIL same_edge_drain wait=%0d gaps=%0d required=0/0", fw, gp); end
    end
  endtask
`else
  task automatic test_blocking;
    int w, fw, gp;
    out_ready = 1'b1;
    send_cols(2, 0, 31, w);
    in_valid = 1'b1;
    in_data  = col_data(3, 0);
    for (int r = 0; r < NW; r++) begin
      total++;
      if (in_ready !== 1'b0 || out_data !== exp_row(2, r)) begin
        bad++;
        $display("FAIL block_drain row=%0d in_ready=%0b data=%h required=0/%h", r, in_ready, out_data, exp_row(2, r));
      end
      @(negedge clk);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL block_release in_ready=%0b required=1", in_ready); end
    send_cols(3, 0, 31, w);
    total++; if (w !== 0) begin bad++; $display("FAIL block_refill stalls=%0d required=0", w); end
    recv_tile(3, fw, gp);
  endtask
`endif

  task automatic test_reset_mid;
    int w, fw, gp;
    out_ready = 1'b0;
    send_cols(4, 0, 9, w);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state busy=%0b valid=%0b ready=%0b last=%0b required=0/0/1/0", busy, out_valid, in_ready, out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_cols(5, 0, 30, w);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_early_valid got=%0b required=0", out_valid); end
    send_cols(5, 31, 31, w);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%0b required=1", out_valid); end
    recv_tile(5, fw, gp);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_done_busy got=%0b required=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_stall();
`ifdef TRANS_YBUF_PINGPONG_EN
    test_stream();
    test_same_edge();
`else
    test_blocking();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/trans_ybuf_colwr.md
TRANS_YBUF_COLWR -- requirements
Module: trans_ybuf_colwr

Interface
REQ-001 SHALL have parameter WORD_WID, default 8, meaning bits per word.
REQ-002 SHALL have parameter CH_X, default 32, meaning words per output row and columns per tile.
REQ-003 SHALL have parameter NUM_WORDS, default 16, meaning words per column and rows per tile.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a column beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-008 SHALL have port in_data, input, NUM_WORDS*WORD_WID bits: one column, word n is the row-n element.
REQ-009 SHALL have port out_valid, output, 1 bit: a row is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the row.
REQ-011 SHALL have port out_data, output, CH_X*WORD_WID bits: one row, word m is the column-m element.
REQ-012 SHALL have port out_last, output, 1 bit: the presented row is row NUM_WORDS-1.
REQ-013 SHALL have port busy, output, 1 bit: at least one bank is not EMPTY.

Function
REQ-014 SHALL accept an input beat on a rising clk edge with in_valid&&in_ready, and write in_data into column col_cnt of the fill bank.
REQ-015 SHALL keep col_cnt in the range 0..CH_X-1 and wrap it to 0 after the beat at CH_X-1; that beat moves the bank FILLING->FULL.
REQ-016 SHALL give each bank the states EMPTY, FILLING, FULL and DRAINING.
- EMPTY->FILLING on the first accepted beat.
- FILLING->FULL after the CH_X-th beat.
- FULL->DRAINING when the bank becomes the read bank.
- DRAINING->EMPTY on the handshake of row NUM_WORDS-1.
REQ-017 SHALL drive in_ready=1 exactly when the fill bank is EMPTY or FILLING; in_ready has no combinational dependence on in_valid.
REQ-018 SHALL assert out_valid in the first cycle after the edge that made a bank FULL; the latency from the last column to the first row is 1 cycle.
REQ-019 SHALL drive out_data combinationally with row row_cnt of the read bank, and word m of that row equals column m word row_cnt.
REQ-020 SHALL hold out_data, out_valid and out_last stable while out_valid&&!out_ready.
REQ-021 SHALL advance row_cnt on each out_valid&&out_ready, wrapping after NUM_WORDS-1, and assert out_last when row_cnt==NUM_WORDS-1.
REQ-022 SHALL drain banks strictly in fill order.
REQ-023 SHALL, when a bank finishes draining on the same edge another bank finishes filling, present row 0 of the newly full bank in the next cycle with no bubble beyond REQ-018.
REQ-024 SHALL sustain back-to-back accepted beats and rows without idle cycles when the consumer is always ready.

Reset
REQ-025 SHALL on rst force all banks EMPTY, col_cnt=0, row_cnt=0, fill pointer and read pointer = bank 0, in_ready=1, out_valid=0, out_last=0 and busy=0.
REQ-026 SHALL not clear bank storage on reset.
REQ-027 SHALL discard any partial or undrained tile on a reset asserted mid-operation, and the first post-reset beat is column 0 of bank 0.

Configuration
REQ-028 SHALL, with TRANS_YBUF_PINGPONG_EN defined, instantiate 2 banks so one fills while the other drains, with pointers toggling per tile.
REQ-029 SHALL, without TRANS_YBUF_PINGPONG_EN, instantiate 1 bank with in_ready=0 from FULL until that bank returns to EMPTY.

Structure
REQ-030 SHALL place the WORD_WID, CH_X and NUM_WORDS defaults and the bank state enum (EMPTY, FILLING, FULL, DRAINING) in shared package trans_pkg.
REQ-031 SHALL implement storage as sub-module trans_ybuf_bank.
- Flop array with column write enable and column index.
- Combinational row read by row index.
- No reset on storage.
REQ-032 SHALL keep the bank state machines, counters and pointers in the top level.

Verification
REQ-033 Bench SHALL cover a single tile: 32 beats with column c word n = {c[3:0],n[3:0]} -> out_valid 1 cycle after beat 32, row r word m = {m[3:0],r[3:0]}, out_last on row 15 only.
REQ-034 Bench SHALL cover out_ready low for 5 cycles on row 3 -> out_data and out_last held stable, row 4 follows the first handshake.
REQ-035 Bench SHALL cover a streaming run with PINGPONG_EN, 4 tiles and in_valid=out_ready=1 -> in_ready never drops, 64 rows out in tile order, no bubbles after the first tile.
REQ-036 Bench SHALL cover the build without PINGPONG_EN with 2 tiles offered back-to-back -> in_ready=0 from beat 32 until the edge after the row-15 handshake.
REQ-037 Bench SHALL cover rst asserted after 10 beats -> busy=0 and out_valid=0, then 32 new beats produce a tile of only the new data.
REQ-038 Bench SHALL cover a bank draining on the same edge the other completes filling -> row 0 of the new tile valid in the next cycle.
